prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Upstream program-load stage for the 8-bit accumulator CPU. It receives a framed byte stream over a valid/ready handshake and writes the payload into the 16-entry program memory. The CPU's memory fetch uses a 4-bit address. The block holds the CPU in reset until a complete frame with a good checksum has been loaded, then releases it. It can re-arm on request.

Parameters:
DEPTH, 16, program memory entries; also the maximum payload length.
ADDR_W, 4, memory address width (log2 DEPTH).
DATA_W, 8, byte width of stream and memory.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  stream byte valid.
in_data  input  DATA_W  stream byte.
in_ready  output  1  loader can accept a byte.
load_req  input  1  abort or re-arm: restart frame reception.
mem_we  output  1  program memory write strobe, one cycle per byte.
mem_addr  output  ADDR_W  program memory write address.
mem_wdata  output  DATA_W  program memory write data.
cpu_reset  output  1  hold-CPU-in-reset; drives the CPU's reset.
busy  output  1  frame reception in progress (DATA or CSUM state).
done  output  1  frame loaded and verified; CPU running.
err  output  1  sticky frame error.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset; sampled on the rising edge of clk only.
- Frame format: LEN byte (N), then N payload bytes, then a CSUM byte. CSUM is the sum of the payload bytes mod 256.
- Transfer occurs on a rising edge when in_valid and in_ready are both 1. in_ready is a registered function of state: 1 in LEN, DATA and CSUM; 0 in RUN and ERR.
- States:
  - LEN: accept the length byte.
    - If 1 <= N <= DEPTH: latch N; clear index and sum to 0; go to DATA.
    - If N = 0 or N > DEPTH: go to ERR.
  - DATA: on each transfer:
    - Register mem_we=1, mem_addr=index, mem_wdata=in_data. The write is visible the cycle after the transfer (1-cycle latency).
    - mem_we returns to 0 on the following cycle unless another transfer occurs.
    - sum <= sum + in_data, truncated to 8 bits.
    - index <= index + 1.
    - After the N-th payload byte, go to CSUM. The index never wraps: N <= DEPTH.
  - CSUM: on a transfer:
    - in_data == sum: go to RUN.
    - Otherwise: go to ERR.
    - No memory write occurs.
  - RUN: cpu_reset=0, done=1. Bytes on the stream are ignored because in_ready=0.
  - ERR: err=1, cpu_reset=1. Stays here until load_req or reset.
- Output registers:
  - cpu_reset=0 only in RUN; it deasserts on the edge that enters RUN.
  - done=1 only in RUN.
  - busy=1 in DATA and CSUM.
- load_req:
  - In any state, load_req=1 moves the block to LEN on the next edge.
  - Effects on that edge: err and done cleared; cpu_reset=1; in_ready=1; index and sum cleared.
  - load_req has priority over a simultaneous transfer. That byte is consumed and discarded, and no write is issued for it.
  - Entries already written by an aborted frame keep their values.
- Memory entries at addresses >= N are never written and never cleared.
- Reset values (applied on any edge where reset=1, including mid-frame):
  - state=LEN, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, err=0.
  - Internal index, sum and N are cleared to 0.
  - A pending write from the transfer on the reset edge is suppressed.
- reset has priority over load_req and over transfers.

Test Plan:
- Good frame: stream 0x03,0x15,0x72,0xC4,0x4B with in_valid held high. Required: writes (0,0x15),(1,0x72),(2,0xC4) on consecutive cycles; then done=1, cpu_reset=0, in_ready=0; err=0 throughout.
- Checksum mismatch: stream 0x02,0x1A,0x25 with CSUM 0x00 (correct value is 0x3F). Required: 2 writes; then err=1 and cpu_reset=1 held. Pulse load_req: err=0, in_ready=1, state LEN.
- Full depth with wrap: N=0x10, sixteen 0xFF bytes, CSUM 0xF0. Required: addresses 0..15 written, done=1. Repeat with N=0x11: immediate err=1 and no writes.
- Back-pressure: toggle in_valid 1,0,0,1,1 during the 0x03 frame. Required: exactly one mem_we pulse per accepted byte, addresses consecutive, no duplicate writes.
- Abort and re-arm: send 0x04,0xAA,0xBB, then assert load_req together with a 0xCC transfer. Required: 0xCC not written, busy=0. A subsequent valid 0x01,0x99,0x99 frame reaches done=1. From RUN, load_req reasserts cpu_reset=1 on the next edge.
- Reset mid-frame: assert reset after 0x03,0x11 has been accepted. Required: all outputs at reset values on the next edge, no write of the following byte, cpu_reset=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (LEN, N payload bytes, CSUM) over
// valid/ready, writes the payload into program memory and holds the CPU in reset
// until a frame with a good checksum has landed.
// Ports: clk/reset (sync, active-high); in_valid/in_data/in_ready stream input;
// load_req re-arm/abort; mem_we/mem_addr/mem_wdata memory write port;
// cpu_reset, busy, done, err status outputs (all registered).
module prog_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              load_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // One extra bit so a full-depth length (N = DEPTH) is representable.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(DEPTH);
   localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  idx;
   logic [CNT_W-1:0]  len;
   logic [DATA_W-1:0] sum;
   logic              xfer;

   assign xfer = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LEN;
         in_ready  <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         idx       <= '0;
         len       <= '0;
         sum       <= '0;
      end else begin
         // Write strobe is a single-cycle pulse unless another byte lands.
         mem_we <= 1'b0;
         if (load_req) begin
            // Any byte transferred on this edge is swallowed without a write.
            state     <= S_LEN;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            sum       <= '0;
         end else begin
            case (state)
               S_LEN: begin
                  if (xfer) begin
                     if (in_data != '0 && in_data <= MAX_LEN) begin
                        len   <= in_data[CNT_W-1:0];
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= S_DATA;
                     end else begin
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_ERR;
                     end
                  end
               end
               S_DATA: begin
                  if (xfer) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= idx[ADDR_W-1:0];
                     mem_wdata <= in_data;
                     sum       <= sum + in_data;
                     idx       <= idx + ONE;
                     if (idx + ONE == len) begin
                        state <= S_CSUM;
                     end
                  end
               end
               S_CSUM: begin
                  if (xfer) begin
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     if (in_data == sum) begin
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_RUN;
                     end else begin
                        err   <= 1'b1;
                        state <= S_ERR;
                     end
                  end
               end
               S_RUN: begin
                  // CPU runs; stream is blocked until a re-arm.
               end
               S_ERR: begin
                  // Sticky until load_req or reset.
               end
               default: begin
                  state    <= S_ERR;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames from the load sequence plus random frames,
// checked against a frame-level reference model (expected writes, memory image
// and final status derived from the frame contents alone).
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       load_req = 1'b0;
   logic       in_ready, mem_we, cpu_reset, busy, done, err;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;

   prog_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .load_req(load_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int d;
      int c;
   } wr_t;

   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   bit         err_seen = 0;
   wr_t        wr_q[$];
   wr_t        exp_q[$];
   logic [7:0] tb_mem[16];
   logic [7:0] model_mem[16];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
         tb_mem[mem_addr] = mem_wdata;
      end
      if (err) err_seen = 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      in_valid = 1'b0;
      repeat (k) step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && w < 20) begin
         step();
         w++;
      end
      check("in_ready_wait", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic status(input string tag, input bit rdy, input bit bsy,
                         input bit dn, input bit er, input bit cr);
      check({tag, "_in_ready"}, in_ready, rdy);
      check({tag, "_busy"}, busy, bsy);
      check({tag, "_done"}, done, dn);
      check({tag, "_err"}, err, er);
      check({tag, "_cpu_reset"}, cpu_reset, cr);
   endtask

   task automatic rearm();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      wr_q.delete();
      exp_q.delete();
      err_seen = 0;
   endtask

   task automatic check_writes(input string tag, input bit consec);
      check({tag, "_nwr"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         check({tag, "_addr"}, wr_q[i].a, exp_q[i].a);
         check({tag, "_data"}, wr_q[i].d, exp_q[i].d);
         if (consec && i > 0) check({tag, "_consec"}, wr_q[i].c - wr_q[i-1].c, 1);
      end
   endtask

   // Reference frame semantics: a legal length writes every payload byte at
   // its index; the frame runs only if the checksum matches the byte sum.
   function automatic bit frame_runs(input logic [7:0] n, input logic [7:0] pl[$],
                                     input logic [7:0] cs);
      int s = 0;
      if (n < 1 || n > 16) return 0;
      foreach (pl[i]) s += pl[i];
      return (s % 256) == cs;
   endfunction

   task automatic send_frame(input logic [7:0] n, input logic [7:0] pl[$],
                             input logic [7:0] cs, input int gap_pct);
      send_byte(n);
      if (n >= 1 && n <= 16) begin
         foreach (pl[i]) begin
            if ($urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
            send_byte(pl[i]);
            exp_q.push_back('{i, int'(pl[i]), 0});
            model_mem[i] = pl[i];
         end
         send_byte(cs);
      end
      step();
   endtask

   initial begin
      logic [7:0] pl[$];
      logic [7:0] n, cs;
      bit         run;
      int         s;

      foreach (tb_mem[i]) begin
         tb_mem[i]    = 8'h00;
         model_mem[i] = 8'h00;
      end

      // Reset state
      repeat (2) step();
      status("rst", 1, 0, 0, 0, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b0;
      step();

      // Good frame, in_valid held high
      err_seen = 0;
      send_byte(8'h03);
      check("good_busy", busy, 1);
      pl = '{8'h15, 8'h72, 8'hC4};
      foreach (pl[i]) begin
         send_byte(pl[i]);
         exp_q.push_back('{i, int'(pl[i]), 0});
         model_mem[i] = pl[i];
      end
      send_byte(8'h4B);
      step();
      status("good", 0, 0, 1, 0, 0);
      check_writes("good", 1);
      check("good_err_seen", err_seen, 0);

      // Checksum mismatch
      rearm();
      send_frame(8'h02, '{8'h1A, 8'h25}, 8'h00, 0);
      check_writes("badcs", 1);
      status("badcs", 0, 0, 0, 1, 1);
      idle(3);
      status("badcs_hold", 0, 0, 0, 1, 1);
      rearm();
      status("badcs_rearm", 1, 0, 0, 0, 1);

      // Full depth, then over-length
      pl.delete();
      repeat (16) pl.push_back(8'hFF);
      send_frame(8'h10, pl, 8'hF0, 0);
      check_writes("full", 1);
      status("full", 0, 0, 1, 0, 0);
      rearm();
      send_frame(8'h11, '{}, 8'h00, 0);
      check_writes("over", 0);
      status("over", 0, 0, 0, 1, 1);

      // Back-pressure: valid pattern 1,0,0,1,1 over the frame start
      rearm();
      send_byte(8'h03);
      idle(2);
      pl = '{8'h21, 8'h32, 8'h43};
      foreach (pl[i]) begin
         send_byte(pl[i]);
         exp_q.push_back('{i, int'(pl[i]), 0});
         model_mem[i] = pl[i];
      end
      send_byte(8'h96);
      step();
      check_writes("bp", 0);
      status("bp", 0, 0, 1, 0, 0);

      // Abort with simultaneous transfer, then re-load
      rearm();
      send_byte(8'h04);
      send_byte(8'hAA);
      send_byte(8'hBB);
      exp_q.push_back('{0, 8'hAA, 0});
      exp_q.push_back('{1, 8'hBB, 0});
      model_mem[0] = 8'hAA;
      model_mem[1] = 8'hBB;
      in_valid = 1'b1;
      in_data  = 8'hCC;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      in_valid = 1'b0;
      status("abort", 1, 0, 0, 0, 1);
      step();
      check_writes("abort", 1);
      wr_q.delete();
      exp_q.delete();
      send_frame(8'h01, '{8'h99}, 8'h99, 0);
      check_writes("reload", 0);
      status("reload", 0, 0, 1, 0, 0);
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      check("run_rearm_cpu_reset", cpu_reset, 1);
      check("run_rearm_done", done, 0);
      wr_q.delete();
      exp_q.delete();

      // Reset mid-frame
      send_byte(8'h03);
      send_byte(8'h11);
      exp_q.push_back('{0, 8'h11, 0});
      model_mem[0] = 8'h11;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h22;
      step();
      status("midrst", 1, 0, 0, 0, 1);
      check("midrst_mem_we", mem_we, 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_mem_wdata", mem_wdata, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      step();
      check_writes("midrst", 0);

      // Random frames
      for (int f = 0; f < 25; f++) begin
         rearm();
         n = 8'($urandom_range(18, 0));
         pl.delete();
         s = 0;
         if (n >= 1 && n <= 16) begin
            for (int i = 0; i < n; i++) begin
               pl.push_back(8'($urandom));
               s += pl[i];
            end
         end
         cs = 8'(s);
         if ($urandom_range(99) < 30) cs = cs + 8'($urandom_range(255, 1));
         run = frame_runs(n, pl, cs);
         send_frame(n, pl, cs, 30);
         check_writes("rnd", 0);
         status("rnd", 0, 0, run, !run, !run);
      end

      foreach (model_mem[i]) check("mem_image", tb_mem[i], model_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
